// File: rtl/bf_relax_sched.sv
// Sequencing controller around the 4-lane Bellman-Ford update sorter: feeds groups in,
// drains sorted slots one per cycle into distance-memory writes. Option: BF_DIST_SAT_EN.
module bf_relax_sched #(
    parameter int IDX_W = 5,
    parameter int DST_W = 7,
    parameter int EWT_W = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    input  logic [EWT_W+2*IDX_W+DST_W-1:0]   in_w0,
    input  logic [EWT_W+2*IDX_W+DST_W-1:0]   in_w1,
    input  logic [EWT_W+2*IDX_W+DST_W-1:0]   in_w2,
    input  logic [EWT_W+2*IDX_W+DST_W-1:0]   in_w3,
    output logic [EWT_W+2*IDX_W+DST_W-1:0]   srt_a,
    output logic [EWT_W+2*IDX_W+DST_W-1:0]   srt_b,
    output logic [EWT_W+2*IDX_W+DST_W-1:0]   srt_c,
    output logic [EWT_W+2*IDX_W+DST_W-1:0]   srt_d,
    input  logic [EWT_W+2*IDX_W+DST_W:0]     srt_a_new,
    input  logic [EWT_W+2*IDX_W+DST_W:0]     srt_b_new,
    input  logic [EWT_W+2*IDX_W+DST_W:0]     srt_c_new,
    input  logic [EWT_W+2*IDX_W+DST_W:0]     srt_d_new,
    output logic [IDX_W-1:0]                 rd_addr,
    input  logic [DST_W-1:0]                 rd_data,
    output logic                             wr_en,
    output logic [IDX_W-1:0]                 wr_addr,
    output logic [DST_W-1:0]                 wr_data,
    output logic                             iter_done,
    output logic                             iter_changed,
    output logic [7:0]                       iter_cnt
);
    localparam int WORD_W = EWT_W + 2*IDX_W + DST_W;
    localparam int J_LO   = DST_W;
    localparam int I_LO   = DST_W + IDX_W;
    localparam int WIJ_LO = DST_W + 2*IDX_W;

    typedef enum logic [1:0] {IDLE, SORT, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WORD_W:0]   slot [4];
    logic [1:0]        k;
    logic              last_flag;
    logic              changed_flag;

    logic [WORD_W:0]   cur;
    logic [DST_W-1:0]  cur_wi;
    logic [IDX_W-1:0]  cur_j;
    logic [EWT_W-1:0]  cur_wij;
    logic              cur_upd;
    logic [DST_W:0]    cand;
    logic [DST_W:0]    cand_eff;
    logic [DST_W-1:0]  dist_eff;
    logic              blocked;
    logic              do_write;
    logic              unused_bits;

    assign cur      = slot[k];
    assign cur_wi   = cur[DST_W-1:0];
    assign cur_j    = cur[J_LO +: IDX_W];
    assign cur_wij  = cur[WIJ_LO +: EWT_W];
    assign cur_upd  = cur[WORD_W];
    assign rd_addr  = cur_j;
    assign cand     = (DST_W+1)'(cur_wij) + {1'b0, cur_wi};

    // A write still in its strobe cycle has not reached memory yet, so a same-j
    // slot right behind it must compare against the pending value.
    assign dist_eff = (wr_en && (wr_addr == rd_addr)) ? wr_data : rd_data;

`ifdef BF_DIST_SAT_EN
    localparam logic [DST_W:0] CAND_SAT = {1'b0, {(DST_W-1){1'b1}}, 1'b0};
    assign blocked     = &cur_wi;
    assign cand_eff    = (cand > CAND_SAT) ? CAND_SAT : cand;
    assign unused_bits = ^cur[I_LO +: IDX_W];
`else
    assign blocked     = 1'b0;
    assign cand_eff    = {1'b0, cand[DST_W-1:0]};
    assign unused_bits = ^{cur[I_LO +: IDX_W], cand[DST_W]};
`endif

    assign do_write = (state == DRAIN) && cur_upd && !blocked &&
                      (cand_eff < {1'b0, dist_eff});

    assign in_ready     = (state == IDLE);
    assign iter_done    = (state == DONE);
    assign iter_changed = (state == DONE) && changed_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid) state_nxt = SORT;
            SORT:  state_nxt = DRAIN;
            DRAIN: if (k == 2'd3) state_nxt = last_flag ? DONE : IDLE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srt_a     <= '0;
            srt_b     <= '0;
            srt_c     <= '0;
            srt_d     <= '0;
            last_flag <= 1'b0;
            slot[0]   <= '0;
            slot[1]   <= '0;
            slot[2]   <= '0;
            slot[3]   <= '0;
            k         <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                srt_a     <= in_w0;
                srt_b     <= in_w1;
                srt_c     <= in_w2;
                srt_d     <= in_w3;
                last_flag <= in_last;
            end
            if (state == SORT) begin
                slot[0] <= srt_a_new;
                slot[1] <= srt_b_new;
                slot[2] <= srt_c_new;
                slot[3] <= srt_d_new;
                k       <= '0;
            end else if (state == DRAIN) begin
                k <= k + 2'd1;
            end
        end
    end

    // Write strobe, iteration bookkeeping; a write decided on slot 3 is already
    // folded into changed_flag by the time DONE reports it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            changed_flag <= 1'b0;
            iter_cnt     <= '0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_addr      <= cur_j;
                wr_data      <= cand_eff[DST_W-1:0];
                changed_flag <= 1'b1;
            end
            if (state == DONE) begin
                changed_flag <= 1'b0;
                iter_cnt     <= iter_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_bf_relax_sched.sv
// Scoreboarded bench for bf_relax_sched: a pass-through sorter and a distance memory
// model surround the DUT; expected writes are predicted when each group is sent.
module tb_bf_relax_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [20:0] in_w0 = '0, in_w1 = '0, in_w2 = '0, in_w3 = '0;
    logic [20:0] srt_a, srt_b, srt_c, srt_d;
    logic [21:0] srt_a_new, srt_b_new, srt_c_new, srt_d_new;
    logic [4:0]  rd_addr;
    logic [6:0]  rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [6:0]  wr_data;
    logic        iter_done;
    logic        iter_changed;
    logic [7:0]  iter_cnt;

    logic [3:0]  upd = '0;
    logic [6:0]  dist_mem [32];
    logic [6:0]  mdist [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [6:0]  pre_val = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_iter = 0;

    typedef struct {
        int         cyc;
        logic [4:0] addr;
        logic [6:0] data;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign srt_a_new = {upd[0], srt_a};
    assign srt_b_new = {upd[1], srt_b};
    assign srt_c_new = {upd[2], srt_c};
    assign srt_d_new = {upd[3], srt_d};
    assign rd_data   = dist_mem[rd_addr];

    always @(posedge clk) begin
        if (pre_en) dist_mem[pre_addr] <= pre_val;
        if (rst_n && wr_en) dist_mem[wr_addr] <= wr_data;
    end

    bf_relax_sched dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_w0(in_w0), .in_w1(in_w1), .in_w2(in_w2), .in_w3(in_w3),
        .srt_a(srt_a), .srt_b(srt_b), .srt_c(srt_c), .srt_d(srt_d),
        .srt_a_new(srt_a_new), .srt_b_new(srt_b_new),
        .srt_c_new(srt_c_new), .srt_d_new(srt_d_new),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iter_done(iter_done), .iter_changed(iter_changed), .iter_cnt(iter_cnt)
    );

    function automatic logic [20:0] mk(input logic [3:0] wij, input logic [4:0] i,
                                       input logic [4:0] j, input logic [6:0] wi);
        return {wij, i, j, wi};
    endfunction

    task automatic set_dist(input logic [4:0] j, input logic [6:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = j; pre_val = v;
        mdist[j] = v;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wr_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write got addr=%0d data=%0d cyc=%0d, required no write",
                             wr_addr, wr_data, cyc);
                end else begin
                    e = sb.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc)
                    begin
                        errors++;
                        $display("[TB] FAIL write got addr=%0d data=%0d cyc=%0d, required addr=%0d data=%0d cyc=%0d",
                                 wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
                    end
                end
            end
        end
    endtask

    // Drives one group at the next free handshake and predicts its writes.
    task automatic send_group(input logic [20:0] w0, input logic [20:0] w1,
                              input logic [20:0] w2, input logic [20:0] w3,
                              input logic [3:0] u, input logic last, output int acc);
        logic [20:0] w [4];
        logic [7:0]  cand8;
        logic [6:0]  cv;
        logic        better;
        int          n;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("[TB] FAIL accept_timeout got in_ready=0, required 1");
        end
        in_w0 = w0; in_w1 = w1; in_w2 = w2; in_w3 = w3;
        in_last = last; upd = u; in_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (u[s]) begin
                cand8 = {4'b0, w[s][20:17]} + {1'b0, w[s][6:0]};
`ifdef BF_DIST_SAT_EN
                cv     = (cand8 > 8'd126) ? 7'd126 : cand8[6:0];
                better = (w[s][6:0] != 7'd127) && (cv < mdist[w[s][11:7]]);
`else
                cv     = cand8[6:0];
                better = cv < mdist[w[s][11:7]];
`endif
                if (better) begin
                    sb.push_back('{cyc: acc + 2 + s, addr: w[s][11:7], data: cv});
                    mdist[w[s][11:7]] = cv;
                end
            end
        end
    endtask

    task automatic wait_drained(input string name);
        repeat (8) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_missing_writes got %0d pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        logic [20:0] w;
        w = mk(4'd1, 5'd2, 5'd3, 7'd4);
        in_valid = 1'b1; in_w0 = w; upd = '0; in_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || wr_en !== 1'b0 || iter_cnt !== 8'd0) begin
                errors++;
                $display("[TB] FAIL reset_values got ready=%b wr_en=%b iter_cnt=%0d, required 1 0 0",
                         in_ready, wr_en, iter_cnt);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || srt_a !== w) begin
            errors++;
            $display("[TB] FAIL accept_after_release got ready=%b srt_a=%h, required 0 %h",
                     in_ready, srt_a, w);
        end
        in_valid = 1'b0;
        wait_drained("reset");
    endtask

    task automatic test_single_write();
        int acc;
        set_dist(5'd3, 7'd20);
        send_group(mk(4'd2, 5'd1, 5'd3, 7'd10), mk(4'd0, 5'd1, 5'd3, 7'd0),
                   mk(4'd0, 5'd2, 5'd4, 7'd0), mk(4'd1, 5'd3, 5'd6, 7'd1),
                   4'b0001, 1'b0, acc);
        wait_drained("single");
    endtask

    task automatic test_forwarding();
        int acc;
        set_dist(5'd5, 7'd30);
        send_group(mk(4'd4, 5'd1, 5'd5, 7'd5), mk(4'd4, 5'd2, 5'd5, 7'd3),
                   '0, '0, 4'b0011, 1'b0, acc);
        wait_drained("fwd_9_7");
        set_dist(5'd5, 7'd30);
        send_group(mk(4'd4, 5'd2, 5'd5, 7'd3), mk(4'd4, 5'd1, 5'd5, 7'd5),
                   '0, '0, 4'b0011, 1'b0, acc);
        wait_drained("fwd_7_9");
    endtask

    task automatic test_iteration(input logic exp_changed);
        int acc;
        int n;
        send_group(mk(4'd2, 5'd1, 5'd10, 7'd10), '0, '0, '0, 4'b0001, 1'b1, acc);
        exp_iter++;
        n = 0;
        while (!iter_done && n < 12) begin @(negedge clk); n++; end
        checks++;
        if (iter_done !== 1'b1 || iter_changed !== exp_changed || cyc != acc + 5) begin
            errors++;
            $display("[TB] FAIL iter_done got done=%b changed=%b cyc=%0d, required 1 %b %0d",
                     iter_done, iter_changed, cyc, exp_changed, acc + 5);
        end
        @(negedge clk);
        checks++;
        if (iter_cnt !== 8'(exp_iter) || iter_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL iter_cnt got %0d done=%b, required %0d 0", iter_cnt, iter_done, exp_iter);
        end
        wait_drained("iter");
    endtask

    task automatic test_saturation();
        int acc;
        set_dist(5'd7, 7'd5);
        set_dist(5'd9, 7'd127);
        send_group(mk(4'd1, 5'd0, 5'd7, 7'd127), mk(4'd4, 5'd0, 5'd9, 7'd125),
                   '0, '0, 4'b0011, 1'b0, acc);
        wait_drained("sat");
    endtask

    task automatic test_reset_mid();
        int acc;
        int n;
        for (int j = 20; j < 24; j++) set_dist(5'(j), 7'd100);
        set_dist(5'd24, 7'd50);
        send_group(mk(4'd1, 5'd0, 5'd20, 7'd1), mk(4'd1, 5'd0, 5'd21, 7'd1),
                   mk(4'd1, 5'd0, 5'd22, 7'd1), mk(4'd1, 5'd0, 5'd23, 7'd1),
                   4'b1111, 1'b1, acc);
        n = 0;
        while (cyc != acc + 2 && n < 10) begin @(negedge clk); n++; end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || in_ready !== 1'b1 || iter_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset got wr_en=%b ready=%b iter_cnt=%0d, required 0 1 0",
                     wr_en, in_ready, iter_cnt);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_group(mk(4'd1, 5'd0, 5'd24, 7'd1), '0, '0, '0, 4'b0001, 1'b0, acc);
        wait_drained("after_reset");
    endtask

    initial begin
        fork
            monitor();
        join_none
        #2 rst_n = 1'b0;
        for (int j = 0; j < 32; j++) set_dist(5'(j), 7'd127);
        @(negedge clk);
        test_reset();
        test_single_write();
        test_forwarding();
        test_iteration(1'b1);
        test_iteration(1'b0);
        test_saturation();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bf_relax_sched.md
Name: bf_relax_sched

Overview:
- Sequencing controller wrapped around the 4-lane update sorter of the pipelined Bellman-Ford datapath.
- Accepts one group of four relaxation words per handshake and presents them to the sorter as registered inputs.
- Captures the sorted, duplicate-marked result and drains the four slots one per cycle. For each valid slot it computes the candidate distance, compares it against the distance memory and issues writes.
- Tracks per-iteration "changed" status for the Bellman-Ford termination check.

Parameters:
- IDX_W, 5, node index width (j and i fields)
- DST_W, 7, distance width W[i]
- EWT_W, 4, edge weight width W[i,j]

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  group valid
- in_ready  out  1  controller can accept a group
- in_last  in  1  group is the last of the current iteration
- in_w0..in_w3  in  21 each  relaxation words: [6:0] W[i], [11:7] j, [16:12] i, [20:17] W[i,j]
- srt_a..srt_d  out  21 each  registered sorter inputs
- srt_a_new..srt_d_new  in  22 each  sorter outputs; bit 21 = update valid
- rd_addr  out  IDX_W  distance memory async read address
- rd_data  in  DST_W  dist[rd_addr]
- wr_en  out  1  distance write strobe
- wr_addr  out  IDX_W  write index j
- wr_data  out  DST_W  new distance
- iter_done  out  1  one-cycle pulse at end of iteration
- iter_changed  out  1  valid with iter_done; 1 if any write occurred in the iteration
- iter_cnt  out  8  completed iterations, wraps 255->0

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE; in_ready = 1.
  - srt_*, rd_addr, wr_en, wr_addr, wr_data, iter_done, iter_changed and iter_cnt all 0.
  - Changed flag cleared; last flag cleared.
- FSM states: IDLE, SORT, DRAIN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register in_w0..3 into srt_a..d and in_last into the last flag, then go to SORT.
- SORT:
  - Exactly one cycle; in_ready = 0.
  - At the end of the cycle, capture srt_*_new into four slot registers and clear slot counter k, then go to DRAIN.
- DRAIN:
  - Exactly 4 cycles regardless of slot validity, k = 0..3.
  - rd_addr = slot[k][11:7] combinationally.
  - cand = zero-extended W[i,j] + W[i] in DST_W+1 bits.
  - If slot[k][21] = 1 and cand < {0, dist_eff}, then the next edge registers wr_en = 1, wr_addr = j, wr_data = cand[DST_W-1:0], and sets the changed flag. Otherwise wr_en = 0 next cycle.
  - Forwarding: dist_eff = wr_data when wr_en is currently 1 and wr_addr == rd_addr; otherwise dist_eff = rd_data.
  - After k = 3: go to DONE if the last flag is set, else IDLE.
- DONE:
  - One cycle; iter_done = 1; iter_changed = changed flag (including a write issued from slot 3).
  - iter_cnt increments; changed flag clears; go to IDLE.
- wr_en is a registered single-cycle strobe. The final write of a group lands during the first IDLE/DONE cycle.
- Throughput: one group per 6 cycles (7 with DONE). in_ready = 0 outside IDLE; in_valid is ignored there.
- Reset mid-operation drops the in-flight group. No write is issued after rst_n asserts.

Optional Feature:
- Macro: BF_DIST_SAT_EN.
- Defined:
  - All-ones W[i] (127) means infinity. A slot with W[i] = 127 never writes.
  - cand saturates at 126.
- Undefined: cand is truncated to DST_W bits (wrap) and compared unmodified; 127 has no special meaning.

Test Plan:
- Reset with in_valid = 1 → in_ready = 1, wr_en = 0, iter_cnt = 0 while rst_n = 0; first accept happens 1 cycle after release.
- One group, sorter returns slot0 {upd=1, j=3, W[i]=10, W[i,j]=2}, others upd=0, dist[3] = 20 → single wr_en with addr 3, data 12 on the cycle after the slot0 drain cycle; no other writes.
- Same-j forwarding: slots 0 and 1 both j=5, cands 9 then 7, dist[5] = 30 → writes 9 then 7. Repeat with cands 7 then 9 → only the 7 is written.
- in_last = 1 with one write → iter_done pulse with iter_changed = 1, iter_cnt = 1. A second last group with no improvements → iter_changed = 0, iter_cnt = 2.
- BF_DIST_SAT_EN defined: W[i] = 127 → no write. W[i] = 125, W[i,j] = 4, dist = 127 → write 126. Undefined: same inputs → wr_data = 1.
- Assert rst_n low during DRAIN k = 1 → wr_en = 0 immediately, state IDLE; the next group is processed normally.
